bomb_fuse_ctrl: RTL

- Producer side of the explosion interface. Takes bomberman placement requests, snaps each bomb to the 16-px tile grid, and runs a per-bomb fuse.
- On fuse expiry it drives exploding_bomb_x/y and issues a one-cycle explosion_write_enable pulse. The explosion module consumes these.
- Also provides a registered pixel-hit flag and sprite row/col so the top module can render armed bombs from the bomb ROM.

---
 rtl/bomb_fuse_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bomb_fuse_ctrl.sv
// Bomb placement and fuse controller: snaps requests to the 16-px grid, times each
// bomb's fuse, serialises detonations to the explosion module and flags bomb pixels.
module bomb_fuse_ctrl #(
  parameter int MAX_BOMBS  = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int FUSE_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  input  logic       C,
  output logic [9:0] exploding_bomb_x,
  output logic [9:0] exploding_bomb_y,
  output logic       explosion_write_enable,
  output logic       bomb_on,
  output logic [3:0] bomb_row,
  output logic [3:0] bomb_col,
  output logic [3:0] bomb_count,
  output logic       place_drop
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST  = PW'(TICK_DIV - 1);
  localparam logic [7:0]    FUSE_LAST = 8'(FUSE_TICKS - 1);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_PENDING = 2'd2
  } slot_e;

  slot_e         state_q [MAX_BOMBS];
  slot_e         state_d [MAX_BOMBS];
  logic [9:0]    sx_q    [MAX_BOMBS];
  logic [9:0]    sx_d    [MAX_BOMBS];
  logic [9:0]    sy_q    [MAX_BOMBS];
  logic [9:0]    sy_d    [MAX_BOMBS];
  logic [7:0]    cnt_q   [MAX_BOMBS];
  logic [7:0]    cnt_d   [MAX_BOMBS];

  logic [PW-1:0] presc_q, presc_d;
  logic          c_low_q, c_low_d;
  logic [9:0]    ex_x_q, ex_x_d;
  logic [9:0]    ex_y_q, ex_y_d;
  logic          ewe_q, ewe_d;
  logic          on_q, on_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    count_q, count_d;
  logic          drop_q, drop_d;

  logic          tick, req, dup, free_found, grant_found, hit_found;
  logic [9:0]    tx, ty;

  always_comb begin
    tick    = (presc_q == DIV_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    // c_low_q means "C was low at the last edge"; clearing it in reset makes a
    // button held through reset release wait for a fresh press.
    c_low_d = ~C;
    req     = C & c_low_q;
    tx      = (b_x + 10'd8) & 10'h3F0;
    ty      = (b_y + 10'd8) & 10'h3F0;

    ex_x_d      = ex_x_q;
    ex_y_d      = ex_y_q;
    ewe_d       = 1'b0;
    on_d        = 1'b0;
    row_d       = 4'd0;
    col_d       = 4'd0;
    drop_d      = 1'b0;
    count_d     = 4'd0;
    dup         = 1'b0;
    free_found  = 1'b0;
    grant_found = 1'b0;
    hit_found   = 1'b0;

    for (int i = 0; i < MAX_BOMBS; i++) begin
      state_d[i] = state_q[i];
      sx_d[i]    = sx_q[i];
      sy_d[i]    = sy_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    // Duplicate check, render hit and detonation grant all see pre-edge occupancy.
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (state_q[i] != SLOT_FREE) begin
        if (sx_q[i] == tx && sy_q[i] == ty) dup = 1'b1;
        if (!hit_found &&
            {1'b0, v_x} >= {1'b0, sx_q[i]} && {1'b0, v_x} <= {1'b0, sx_q[i]} + 11'd15 &&
            {1'b0, v_y} >= {1'b0, sy_q[i]} && {1'b0, v_y} <= {1'b0, sy_q[i]} + 11'd15) begin
          hit_found = 1'b1;
          on_d      = 1'b1;
          col_d     = v_x[3:0] - sx_q[i][3:0];
          row_d     = v_y[3:0] - sy_q[i][3:0];
        end
      end
      if (state_q[i] == SLOT_PENDING && !grant_found) begin
        grant_found = 1'b1;
        ex_x_d      = sx_q[i];
        ex_y_d      = sy_q[i];
        ewe_d       = 1'b1;
        state_d[i]  = SLOT_FREE;
      end
      if (state_q[i] == SLOT_ARMED && tick) begin
        if (cnt_q[i] == FUSE_LAST) state_d[i] = SLOT_PENDING;
        else                       cnt_d[i]   = cnt_q[i] + 8'd1;
      end
    end

    // explosion_write_enable is a one-cycle strobe; the coordinates are valid with
    // it and hold until the next strobe. There is no back-pressure.
    if (req) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        if (state_q[i] == SLOT_FREE && !free_found && !dup) begin
          free_found = 1'b1;
          state_d[i] = SLOT_ARMED;
          sx_d[i]    = tx;
          sy_d[i]    = ty;
          cnt_d[i]   = 8'd0;
        end
      end
      drop_d = ~free_found;
    end

    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (state_d[i] != SLOT_FREE) count_d = count_d + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        state_q[i] <= SLOT_FREE;
        sx_q[i]    <= '0;
        sy_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
      presc_q <= '0;
      c_low_q <= 1'b0;
      ex_x_q  <= '0;
      ex_y_q  <= '0;
      ewe_q   <= 1'b0;
      on_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        state_q[i] <= state_d[i];
        sx_q[i]    <= sx_d[i];
        sy_q[i]    <= sy_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      presc_q <= presc_d;
      c_low_q <= c_low_d;
      ex_x_q  <= ex_x_d;
      ex_y_q  <= ex_y_d;
      ewe_q   <= ewe_d;
      on_q    <= on_d;
      row_q   <= row_d;
      col_q   <= col_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign exploding_bomb_x       = ex_x_q;
  assign exploding_bomb_y       = ex_y_q;
  assign explosion_write_enable = ewe_q;
  assign bomb_on                = on_q;
  assign bomb_row               = row_q;
  assign bomb_col               = col_q;
  assign bomb_count             = count_q;
  assign place_drop             = drop_q;

endmodule
